uart_receiver: RTL and testbench

//  UART receive path; the line-side counterpart of the UART transmitter. Receives the 8N1 serial stream

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud/oversampling constants.
// The transmitter imports this package for its baud divisor.
package uart_pkg;

  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned BAUD_DIV_115200 = 27;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBrk
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line.
// Resets to 1 so that an idle line is not mistaken for a start bit.
module uart_rx_sync (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with OVERSAMPLE x oversampling, ready/overrun/framing flags.
// Define RX_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clken_16x,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rdy,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 rx_busy
`ifdef RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SW-1:0] SAMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_e              state_q;
  logic [SW-1:0]          samp_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   rx_s;
`ifdef RX_PARITY_EN
  logic                   par_bit_q;
`endif

  uart_rx_sync u_sync (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign rx_busy = (state_q != StIdle);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      rdy        <= 1'b0;
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_PARITY_EN
      par_bit_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // Acknowledge first; a same-cycle load or error below takes precedence.
      if (rd_en) begin
        rdy       <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
`ifdef RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end
      if (clken_16x) begin
        unique case (state_q)
          StIdle: begin
            if (!rx_s) begin
              state_q    <= StStart;
              samp_cnt_q <= '0;
            end
          end
          StStart: begin
            if (samp_cnt_q == SAMP_MID) begin
              if (!rx_s) begin
                state_q    <= StData;
                samp_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              samp_cnt_q <= samp_cnt_q + 1'b1;
            end
          end
          StData: begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
            if (samp_cnt_q == SAMP_LAST) begin
              shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
              if (bit_cnt_q == BIT_LAST) begin
`ifdef RX_PARITY_EN
                state_q <= StParity;
`else
                state_q <= StStop;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
`ifdef RX_PARITY_EN
          StParity: begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
            if (samp_cnt_q == SAMP_LAST) begin
              par_bit_q <= rx_s;
              state_q   <= StStop;
            end
          end
`endif
          StStop: begin
            samp_cnt_q <= samp_cnt_q + 1'b1;
            if (samp_cnt_q == SAMP_LAST) begin
              if (rx_s) begin
                data_out <= shift_q;
                rdy      <= 1'b1;
                if (rdy && !rd_en) begin
                  overrun <= 1'b1;
                end
`ifdef RX_PARITY_EN
                // Even parity: data plus parity bit must hold an even number of ones.
                if ((^shift_q) != par_bit_q) begin
                  parity_err <= 1'b1;
                end
`endif
                state_q <= StIdle;
              end else begin
                frame_err <= 1'b1;
                state_q   <= StBrk;
              end
            end
          end
          StBrk: begin
            if (rx_s) begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboarded random/directed bench for uart_receiver: a line-level frame generator,
// a transaction-level flag model, and a monitor that checks status at every frame end.
module tb_uart_receiver;

  localparam int unsigned OS = 16;
`ifdef RX_PARITY_EN
  localparam int unsigned NB = 9;
`else
  localparam int unsigned NB = 8;
`endif
  // Line sample index (from the first start-bit sample) on which the stop bit is taken,
  // given a clken period long enough for the synchronizer to settle between ticks.
  localparam int unsigned LOAD_IDX = OS / 2 + 1 + OS * (NB + 1);

  logic       clk_50m = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clken_16x;
  logic       rd_en;
  logic [7:0] data_out;
  logic       rdy;
  logic       overrun;
  logic       frame_err;
  logic       rx_busy;
  logic       perr_w;
`ifdef RX_PARITY_EN
  logic       parity_err;
  assign perr_w = parity_err;
`else
  assign perr_w = 1'b0;
`endif

  uart_receiver dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .rx        (rx),
    .clken_16x (clken_16x),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .rdy       (rdy),
    .overrun   (overrun),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
`ifdef RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct packed {
    logic lv;
    logic rd;
  } ent_t;

  typedef struct packed {
    logic [7:0] data;
    logic       rdy;
    logic       ovr;
    logic       ferr;
    logic       perr;
  } st_t;

  ent_t line_q[$];
  st_t  exp_q[$];
  st_t  m;
  int   vectors     = 0;
  int   miscompares = 0;
  int   div         = 27;
  int   pops        = 0;

  function automatic st_t dut_st();
    return {data_out, rdy, overrun, frame_err, perr_w};
  endfunction

  task automatic cmp(input string name, input st_t got, input st_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got data=%02h rdy=%0b ovr=%0b ferr=%0b perr=%0b, expected data=%02h rdy=%0b ovr=%0b ferr=%0b perr=%0b",
               name, got.data, got.rdy, got.ovr, got.ferr, got.perr,
               exp.data, exp.rdy, exp.ovr, exp.ferr, exp.perr);
    end
  endtask

  task automatic cmp_bit(input string name, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0b, expected %0b", name, got, exp);
    end
  endtask

  // Line level of bit k of a frame: start, data LSB first, optional even parity, stop.
  function automatic logic frame_level(input logic [7:0] b, input bit par_flip,
                                       input bit stop_ok, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 9 && k == 9) return (^b) ^ par_flip;
    return stop_ok;
  endfunction

  task automatic push_idle(input int n);
    ent_t e;
    e.lv = 1'b1;
    e.rd = 1'b0;
    repeat (n) line_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip,
                            input bit rd_at_load, input int gap, input bit want_exp);
    ent_t e;
    int   idx = 0;
    for (int k = 0; k < int'(NB) + 2; k++) begin
      for (int s = 0; s < int'(OS); s++) begin
        e.lv = frame_level(b, par_flip, stop_ok, k);
        e.rd = rd_at_load && (idx == int'(LOAD_IDX));
        line_q.push_back(e);
        idx++;
      end
    end
    if (!stop_ok) begin
      e.lv = 1'b0;
      e.rd = 1'b0;
      repeat (OS) line_q.push_back(e);
      push_idle(OS);
    end
    push_idle(gap);
    if (!want_exp) return;
    if (stop_ok) begin
      if (rd_at_load) begin
        m.ovr  = 1'b0;
        m.ferr = 1'b0;
        m.perr = 1'b0;
      end else begin
        m.ovr = m.ovr | m.rdy;
      end
      if (NB == 9) m.perr = m.perr | par_flip;
      m.rdy  = 1'b1;
      m.data = b;
    end else begin
      m.ferr = 1'b1;
    end
    exp_q.push_back(m);
  endtask

  task automatic push_read();
    ent_t e;
    e.lv = 1'b1;
    e.rd = 1'b1;
    line_q.push_back(e);
    m.rdy  = 1'b0;
    m.ovr  = 1'b0;
    m.ferr = 1'b0;
    m.perr = 1'b0;
  endtask

  task automatic push_glitch();
    ent_t e;
    e.lv = 1'b0;
    e.rd = 1'b0;
    repeat (OS / 4) line_q.push_back(e);
    push_idle(2 * OS);
    exp_q.push_back(m);
  endtask

  task automatic drain(input string name, input int max_cycles);
    int n = 0;
    while ((line_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      @(negedge clk_50m);
      n++;
    end
    if (n >= max_cycles) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: drain timeout, %0d line samples and %0d expected frames pending, expected none",
               name, line_q.size(), exp_q.size());
      line_q.delete();
      exp_q.delete();
    end
    repeat (4 * div + 4) @(negedge clk_50m);
  endtask

  // Line driver: one queue entry per clken tick; rd_en is asserted only on that tick's cycle.
  initial begin
    int   div_cnt = 0;
    ent_t e;
    clken_16x = 1'b0;
    rx        = 1'b1;
    rd_en     = 1'b0;
    forever begin
      @(negedge clk_50m);
      rd_en = 1'b0;
      if (div_cnt >= div - 1) begin
        div_cnt   = 0;
        clken_16x = 1'b1;
        if (line_q.size() > 0) begin
          e     = line_q.pop_front();
          rx    = e.lv;
          rd_en = e.rd;
          pops++;
        end else begin
          rx = 1'b1;
        end
      end else begin
        clken_16x = 1'b0;
        div_cnt++;
      end
    end
  end

  // Monitor: each return to idle closes a frame (good, errored or glitch).
  initial begin
    logic busy_prev = 1'b0;
    st_t  e;
    forever begin
      @(negedge clk_50m);
      if (!rst_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !rx_busy) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_end: got an unexpected return to idle, expected no frame");
          end else begin
            e = exp_q.pop_front();
            cmp("frame_end", dut_st(), e);
          end
        end
        busy_prev = rx_busy;
      end
    end
  end

  initial begin
    int   base;
    int   n;
    logic [7:0] rb;
    m     = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk_50m);
    cmp("reset_state", dut_st(), '0);
    cmp_bit("reset_busy", rx_busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50m);

    // Basic receive and acknowledge.
    push_frame(8'hA5, 1, 0, 0, 4, 1);
    drain("a5_rx", 20000);
    cmp("a5_held", dut_st(), m);
    push_read();
    drain("a5_read", 2000);
    cmp("a5_ack", dut_st(), m);

    // Short glitch on idle line.
    push_glitch();
    drain("glitch", 4000);
    cmp("glitch_flags", dut_st(), m);
    cmp_bit("glitch_idle", rx_busy, 1'b0);

    // Framing error then recovery.
    push_frame(8'h3C, 0, 0, 0, 4, 1);
    drain("ferr", 20000);
    cmp("ferr_state", dut_st(), m);
    push_frame(8'h55, 1, 0, 0, 4, 1);
    drain("after_ferr", 20000);
    push_read();
    drain("after_ferr_read", 2000);
    cmp("after_ferr_ack", dut_st(), m);

    // Overrun, then acknowledge coinciding with the load.
    push_frame(8'h11, 1, 0, 0, 0, 1);
    push_frame(8'h22, 1, 0, 0, 4, 1);
    drain("overrun", 40000);
    cmp("overrun_state", dut_st(), m);
    push_read();
    push_frame(8'h11, 1, 0, 0, 0, 1);
    push_frame(8'h22, 1, 0, 1, 4, 1);
    drain("rd_at_load", 40000);
    cmp("rd_at_load_state", dut_st(), m);
    push_read();
    drain("rd_at_load_read", 2000);

    // Reset in the middle of data bit 4.
    base = pops + line_q.size();
    push_frame(8'hFF, 1, 0, 0, 4, 0);
    n = 0;
    while (pops < base + OS + 4 * OS + OS / 2 && n < 20000) begin
      @(negedge clk_50m);
      n++;
    end
    #3;
    rst_n = 1'b0;
    line_q.delete();
    #1;
    m = '0;
    cmp("midframe_reset", dut_st(), m);
    cmp_bit("midframe_reset_busy", rx_busy, 1'b0);
    repeat (3) @(negedge clk_50m);
    rst_n = 1'b1;
    push_frame(8'h81, 1, 0, 0, 4, 1);
    drain("post_reset", 20000);
    cmp("post_reset_state", dut_st(), m);
    push_read();
    drain("post_reset_read", 2000);

    // Back-to-back stream at one tick per clock.
    div = 1;
    for (int i = 0; i < 256; i++) begin
      push_frame(8'(i), 1, 0, 0, int'($urandom_range(0, 2)), 1);
      push_read();
    end
    drain("stream", 60000);
    cmp("stream_end", dut_st(), m);

`ifdef RX_PARITY_EN
    push_frame(8'h07, 1, 1, 0, 2, 1);
    drain("parity", 2000);
    push_read();
    drain("parity_read", 200);
`endif

    // Random bytes, occasional framing errors and skipped acknowledges.
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom);
      push_frame(rb, ($urandom_range(0, 5) != 0), 0, 0, int'($urandom_range(0, 3)), 1);
      if (m.rdy && $urandom_range(0, 1) == 1) push_read();
    end
    drain("random", 10000);
    cmp("random_end", dut_st(), m);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
